// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and constants for the LC3 memory controller.
//   state_t    - request/acknowledge FSM states
//   acc_kind_t - kind of access latched at grant
//   LC3_NOP    - value IR holds out of reset (BR never)
//   FAIR_LIMIT - consecutive data grants tolerated while a fetch waits
package lc3_pkg;

  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;
  localparam int FAIR_LIMIT = 2;

  localparam logic [LC3_DATA_W-1:0] LC3_NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH,
    K_LOAD,
    K_STORE
  } acc_kind_t;

endpackage

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: arbitrates LC3 instruction fetch and load/store requests
// onto one single-port synchronous SRAM.
//   CLK, RST_N         - clock, synchronous active-low reset
//   IF_REQ/IF_ADDR     - fetch request (held until IF_ACK)
//   IF_ACK/IR          - fetch completion pulse, fetched instruction
//   D_REQ/D_WE/D_ADDR/D_WDATA - load/store request (held until D_ACK)
//   D_ACK/D_RDATA      - data completion pulse, load data
//   MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA/MEM_RDATA - SRAM port
//   BUSY               - FSM outside IDLE, lets the core stall
// Every output is a flop; nothing on the request inputs reaches an output
// combinationally. MEM_LAT must lie in 1..4.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = LC3_ADDR_W,
  parameter int DATA_W  = LC3_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_ACK,
  output logic [DATA_W-1:0] IR,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_ACK,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY
);

  state_t    state;
  acc_kind_t kind;
  logic [2:0] lat_cnt;
  logic [1:0] fair_cnt;
  logic       fetch_win;

  // Data normally wins; a waiting fetch is forced through once data has
  // taken FAIR_LIMIT grants in a row while the fetch was pending.
  assign fetch_win = IF_REQ && (!D_REQ || (fair_cnt == 2'(FAIR_LIMIT)));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      kind      <= K_FETCH;
      lat_cnt   <= '0;
      fair_cnt  <= '0;
      IF_ACK    <= 1'b0;
      D_ACK     <= 1'b0;
      IR        <= DATA_W'(LC3_NOP);
      D_RDATA   <= '0;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      BUSY      <= 1'b0;
    end else begin
      // single-cycle strobes default low
      IF_ACK <= 1'b0;
      D_ACK  <= 1'b0;
      MEM_EN <= 1'b0;
      MEM_WE <= 1'b0;
      case (state)
        ST_IDLE: begin
          // grant edge: latch the winner and raise the SRAM strobe so it
          // is visible in the ISSUE cycle
          if (fetch_win) begin
            kind     <= K_FETCH;
            MEM_ADDR <= IF_ADDR;
            MEM_EN   <= 1'b1;
            BUSY     <= 1'b1;
            fair_cnt <= '0;
            lat_cnt  <= 3'(MEM_LAT);
            state    <= ST_ISSUE;
          end else if (D_REQ) begin
            kind     <= D_WE ? K_STORE : K_LOAD;
            MEM_ADDR <= D_ADDR;
            MEM_WE   <= D_WE;
            if (D_WE) MEM_WDATA <= D_WDATA;
            MEM_EN   <= 1'b1;
            BUSY     <= 1'b1;
            // the streak only counts grants that made a fetch wait
            fair_cnt <= IF_REQ ? fair_cnt + 2'd1 : 2'd0;
            lat_cnt  <= 3'(MEM_LAT);
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (kind == K_STORE) begin
            D_ACK <= 1'b1;
            state <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // lat_cnt hits 0 in the cycle MEM_RDATA is valid
          if (lat_cnt == 3'd0) begin
            if (kind == K_FETCH) begin
              IR     <= MEM_RDATA;
              IF_ACK <= 1'b1;
            end else begin
              D_RDATA <= MEM_RDATA;
              D_ACK   <= 1'b1;
            end
            state <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_DONE: begin
          // requests are not looked at here; they are picked up next IDLE
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
module tb_lc3_mem_ctrl;

  localparam int LAT = 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N = 1'b0;

  // main DUT, MEM_LAT = 1
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic        if_ack, d_ack, mem_en, mem_we, busy;
  logic [15:0] ir, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // second DUT, MEM_LAT = 3, fetch only
  logic        if_req3 = 0;
  logic [15:0] if_addr3 = 0;
  logic        if_ack3, d_ack3, mem_en3, mem_we3, busy3;
  logic [15:0] ir3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int n_cmp = 0;
  int n_bad = 0;

  lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack), .IR(ir),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_ACK(d_ack), .D_RDATA(d_rdata),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .BUSY(busy)
  );

  lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N),
    .IF_REQ(if_req3), .IF_ADDR(if_addr3), .IF_ACK(if_ack3), .IR(ir3),
    .D_REQ(1'b0), .D_WE(1'b0), .D_ADDR(16'h0000), .D_WDATA(16'h0000),
    .D_ACK(d_ack3), .D_RDATA(d_rdata3),
    .MEM_EN(mem_en3), .MEM_WE(mem_we3), .MEM_ADDR(mem_addr3),
    .MEM_WDATA(mem_wdata3), .MEM_RDATA(mem_rdata3), .BUSY(busy3)
  );

  // power-up memory contents: 3000h holds 1234h, everything else a hash
  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5C3);
  endfunction

  // behavioural SRAM for the main DUT
  logic [15:0] sram [logic [15:0]];
  logic [15:0] rd_q = 16'hDEAD;

  function automatic logic [15:0] sram_rd(input logic [15:0] a);
    return sram.exists(a) ? sram[a] : init_word(a);
  endfunction

  always @(posedge CLK) begin
    if (mem_en && mem_we) sram[mem_addr] = mem_wdata;
    rd_q <= (mem_en && !mem_we) ? sram_rd(mem_addr) : 16'hDEAD;
  end
  assign mem_rdata = rd_q;

  // read-only 3-cycle SRAM for the second DUT
  logic [15:0] rd3 [3];
  always @(posedge CLK) begin
    rd3[0] <= mem_en3 ? init_word(mem_addr3) : 16'hDEAD;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign mem_rdata3 = rd3[2];

  // reference memory for the scoreboard
  logic [15:0] exp_mem [logic [15:0]];

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] rnd_addr();
    int r;
    r = $urandom_range(0, 7);
    return (r == 0) ? 16'hFFFF : 16'h4000 + 16'($urandom_range(0, 5));
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    if_req3 = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    n_cmp++;
    if (ir !== 16'h0000) begin
      n_bad++; $display("FAIL reset_ir: got %h want 0000", ir);
    end
    n_cmp++;
    if ({if_ack, d_ack, busy, mem_en, mem_we} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {if_ack, d_ack, busy, mem_en, mem_we});
    end
    n_cmp++;
    if ({d_rdata, mem_addr, mem_wdata} !== 48'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {d_rdata, mem_addr, mem_wdata});
    end
    n_cmp++;
    if ({ir3, if_ack3, busy3, mem_en3} !== 19'h0) begin
      n_bad++; $display("FAIL reset_dut3: got %h want 0", {ir3, if_ack3, busy3, mem_en3});
    end
  endtask

  task automatic test_fetch();
    int k;
    // MEM_LAT = 1: request sampled at end of T
    if_req = 1'b1; if_addr = 16'h3000;
    step(); // T+1
    n_cmp++;
    if ({mem_en, mem_we, busy, mem_addr} !== {3'b101, 16'h3000}) begin
      n_bad++; $display("FAIL fetch_issue: got en/we/busy=%b addr=%h want 101 3000", {mem_en, mem_we, busy}, mem_addr);
    end
    step(); // T+2
    n_cmp++;
    if (if_ack !== 1'b0) begin
      n_bad++; $display("FAIL fetch_early_ack: got %b want 0", if_ack);
    end
    step(); // T+3
    n_cmp++;
    if ({if_ack, ir} !== {1'b1, 16'h1234}) begin
      n_bad++; $display("FAIL fetch_ack: got ack=%b ir=%h want 1 1234", if_ack, ir);
    end
    if_req = 1'b0;
    step();
    n_cmp++;
    if ({if_ack, busy, ir} !== {2'b00, 16'h1234}) begin
      n_bad++; $display("FAIL fetch_after: got ack/busy=%b ir=%h want 00 1234", {if_ack, busy}, ir);
    end
    // MEM_LAT = 3
    if_req3 = 1'b1; if_addr3 = 16'h3000; k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      step();
      if (if_ack3) k = i;
    end
    if_req3 = 1'b0;
    n_cmp++;
    if (k != 5) begin
      n_bad++; $display("FAIL fetch_lat3_cycles: got %0d want 5", k);
    end
    n_cmp++;
    if (ir3 !== 16'h1234) begin
      n_bad++; $display("FAIL fetch_lat3_ir: got %h want 1234", ir3);
    end
    step();
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h4000; d_wdata = 16'hBEEF;
    exp_mem[16'h4000] = 16'hBEEF;
    step(); // T+1
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h4000, 16'hBEEF}) begin
      n_bad++; $display("FAIL store_issue: got en/we=%b addr=%h wd=%h want 11 4000 beef", {mem_en, mem_we}, mem_addr, mem_wdata);
    end
    step(); // T+2
    n_cmp++;
    if ({d_ack, busy, mem_en, mem_we} !== 4'b1100) begin
      n_bad++; $display("FAIL store_ack: got ack/busy/en/we=%b want 1100", {d_ack, busy, mem_en, mem_we});
    end
    d_req = 1'b0;
    step(); // idle; issue the load here
    n_cmp++;
    if ({d_ack, busy} !== 2'b00) begin
      n_bad++; $display("FAIL store_done: got ack/busy=%b want 00", {d_ack, busy});
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4000;
    step(); step(); step();
    n_cmp++;
    if ({d_ack, d_rdata} !== {1'b1, 16'hBEEF}) begin
      n_bad++; $display("FAIL load_data: got ack=%b rdata=%h want 1 beef", d_ack, d_rdata);
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    int kinds[$];
    int exp_seq[6] = '{1, 1, 0, 1, 1, 0};
    logic [15:0] ir_at_grant;
    idle_inputs();
    do_reset();
    if_req = 1'b1; if_addr = 16'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h5000;
    ir_at_grant = 16'h0000;
    for (int c = 0; c < 100 && kinds.size() < 6; c++) begin
      step();
      if (mem_en) begin
        kinds.push_back((mem_addr[15:12] == 4'h5) ? 1 : 0);
        ir_at_grant = ir;
      end
      if (d_ack) begin
        n_cmp++;
        if (ir !== ir_at_grant) begin
          n_bad++; $display("FAIL fair_ir_hold: got %h want %h", ir, ir_at_grant);
        end
        d_addr = d_addr + 16'd1;
      end
    end
    n_cmp++;
    if (kinds.size() != 6) begin
      n_bad++; $display("FAIL fair_timeout: got %0d grants want 6", kinds.size());
    end
    for (int i = 0; i < kinds.size(); i++) begin
      n_cmp++;
      if (kinds[i] != exp_seq[i]) begin
        n_bad++; $display("FAIL fair_order[%0d]: got %0d want %0d (1=data)", i, kinds[i], exp_seq[i]);
      end
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset_mid_read();
    int acks;
    int k;
    idle_inputs();
    if_req = 1'b1; if_addr = 16'h4005;
    step(); step(); // now in WAIT
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_busy_before: got %b want 1", busy);
    end
    RST_N = 1'b0;
    step();
    n_cmp++;
    if ({if_ack, busy, mem_en, mem_we, ir} !== {4'b0000, 16'h0000}) begin
      n_bad++; $display("FAIL rst_mid_state: got ack/busy/en/we=%b ir=%h want 0000 0000", {if_ack, busy, mem_en, mem_we}, ir);
    end
    if_req = 1'b0;
    step();
    RST_N = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (if_ack) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_bad++; $display("FAIL rst_mid_stray_ack: got %0d want 0", acks);
    end
    if_req = 1'b1; if_addr = 16'h3000; k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      step();
      if (if_ack) k = i;
    end
    if_req = 1'b0;
    n_cmp++;
    if ({k[7:0], ir} !== {8'd3, 16'h1234}) begin
      n_bad++; $display("FAIL rst_mid_recover: got cycles=%0d ir=%h want 3 1234", k, ir);
    end
    step();
  endtask

  task automatic test_glitch();
    int en_cnt, dack_cnt, iack_cnt;
    idle_inputs();
    en_cnt = 0; dack_cnt = 0; iack_cnt = 0;
    if_req = 1'b1; if_addr = 16'h3000;
    step(); // fetch in ISSUE
    if (mem_en) en_cnt++;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h4001; d_wdata = 16'h5555;
    step();
    d_req = 1'b0;
    if (mem_en) en_cnt++;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_en) en_cnt++;
      if (d_ack) dack_cnt++;
      if (if_ack) begin iack_cnt++; if_req = 1'b0; end
    end
    n_cmp++;
    if ({en_cnt[3:0], dack_cnt[3:0], iack_cnt[3:0]} !== 12'h101) begin
      n_bad++; $display("FAIL glitch: got en=%0d dack=%0d iack=%0d want 1 0 1", en_cnt, dack_cnt, iack_cnt);
    end
  endtask

  // Random traffic against a transaction-level model: the model decides
  // who should win each grant, when the ACK must appear and what data
  // it must carry, from the arbitration rules and a reference memory.
  task automatic test_random();
    logic        a_v, a_is_store, idle_last, exp_en, fetch;
    int          a_kind, a_ack_cyc, streak;
    logic [15:0] a_addr, a_data, exp_ir, exp_dr;
    logic        exp_ifa, exp_da;
    logic        s_if, s_d, s_we;
    logic [15:0] s_if_addr, s_d_addr, s_wd;
    idle_inputs();
    do_reset();
    a_v = 0; a_kind = 0; a_ack_cyc = -1; a_addr = 0; a_data = 0;
    idle_last = 1; streak = 0; exp_ir = 16'h0000; exp_dr = 16'h0000;
    s_if = 0; s_d = 0; s_we = 0; s_if_addr = 0; s_d_addr = 0; s_wd = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      exp_en = idle_last && (s_if || s_d);
      n_cmp++;
      if (mem_en !== exp_en) begin
        n_bad++; $display("FAIL rnd_en @%0d: got %b want %b", c, mem_en, exp_en);
      end
      if (exp_en) begin
        fetch = s_if && (!s_d || streak == 2);
        if (fetch) begin
          a_kind = 0; a_addr = s_if_addr; streak = 0;
        end else begin
          a_kind = s_we ? 2 : 1; a_addr = s_d_addr;
          streak = s_if ? streak + 1 : 0;
        end
        a_is_store = (a_kind == 2);
        a_v = 1;
        a_ack_cyc = c + (a_is_store ? 1 : 1 + LAT);
        if (a_is_store) exp_mem[a_addr] = s_wd;
        else a_data = exp_rd(a_addr);
        n_cmp++;
        if ({mem_addr, mem_we} !== {a_addr, a_is_store}) begin
          n_bad++; $display("FAIL rnd_grant @%0d: got addr=%h we=%b want %h %b", c, mem_addr, mem_we, a_addr, a_is_store);
        end
        if (a_is_store) begin
          n_cmp++;
          if (mem_wdata !== s_wd) begin
            n_bad++; $display("FAIL rnd_wdata @%0d: got %h want %h", c, mem_wdata, s_wd);
          end
        end
      end
      exp_ifa = a_v && (c == a_ack_cyc) && (a_kind == 0);
      exp_da  = a_v && (c == a_ack_cyc) && (a_kind != 0);
      n_cmp++;
      if ({if_ack, d_ack, busy} !== {exp_ifa, exp_da, a_v}) begin
        n_bad++; $display("FAIL rnd_ctrl @%0d: got ifack/dack/busy=%b want %b", c, {if_ack, d_ack, busy}, {exp_ifa, exp_da, a_v});
      end
      idle_last = !a_v;
      if (exp_ifa) exp_ir = a_data;
      if (exp_da && a_kind == 1) exp_dr = a_data;
      n_cmp++;
      if ({ir, d_rdata} !== {exp_ir, exp_dr}) begin
        n_bad++; $display("FAIL rnd_data @%0d: got ir=%h rdata=%h want %h %h", c, ir, d_rdata, exp_ir, exp_dr);
      end
      if (a_v && c == a_ack_cyc) begin
        a_v = 0;
        if (a_kind == 0) if_req = 1'b0;
        else d_req = 1'b0;
      end
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rnd_addr();
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = rnd_addr(); d_wdata = 16'($urandom);
      end
      s_if = if_req; s_if_addr = if_addr;
      s_d = d_req; s_we = d_we; s_d_addr = d_addr; s_wd = d_wdata;
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_fairness();
    test_reset_mid_read();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory controller that sits directly upstream of the LC3 core and produces the instruction word it consumes (`IR`) and the data word returned for loads. It arbitrates the core's instruction-fetch and data (load/store) requests onto one single-port synchronous SRAM. Accesses are serialized through a request/acknowledge FSM with a parameterizable read latency. `BUSY` lets the core's stage sequencer stall.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `MEM_LAT`, 1: SRAM read latency in cycles. Legal range is 1..4.

Ports:
- `CLK` in 1: the single clock. All logic is on the rising edge.
- `RST_N` in 1: reset. It is synchronous and active-low.
- `IF_REQ` in 1: fetch request. The core holds it high until `IF_ACK`.
- `IF_ADDR` in `ADDR_W`: fetch address, normally PC.
- `IF_ACK` out 1: one-cycle pulse. `IR` is updated in the same cycle.
- `IR` out `DATA_W`: fetched instruction. It holds until the next `IF_ACK`.
- `D_REQ` in 1: data request. The core holds it high until `D_ACK`.
- `D_WE` in 1: data request type. 1 is a store, 0 is a load.
- `D_ADDR` in `ADDR_W`: data address, from MAR.
- `D_WDATA` in `DATA_W`: store data.
- `D_ACK` out 1: one-cycle pulse marking load/store completion.
- `D_RDATA` out `DATA_W`: load data. It holds until the next load `D_ACK`.
- `MEM_EN` out 1: SRAM access strobe, one cycle per access.
- `MEM_WE` out 1: SRAM write enable. It is only asserted together with `MEM_EN`.
- `MEM_ADDR` out `ADDR_W`: SRAM address.
- `MEM_WDATA` out `DATA_W`: SRAM write data.
- `MEM_RDATA` in `DATA_W`: SRAM read data. It is valid `MEM_LAT` cycles after the `MEM_EN` cycle.
- `BUSY` out 1: high whenever the FSM is not in IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:** sample the requests and pick a winner.
  - Data beats fetch when both are pending.
  - Fairness: after 2 consecutive data grants with `IF_REQ` pending, the next grant goes to fetch. The counter clears on any fetch grant.
  - The address, type and write data of the winner are latched at grant. Input changes after grant are ignored.
- **ISSUE:** drive `MEM_EN=1`, the latched `MEM_ADDR`, and for stores `MEM_WE=1` with `MEM_WDATA`.
  - Store: go to DONE.
  - Read: go to WAIT.
- **WAIT:** a latency counter is loaded with `MEM_LAT` in ISSUE and decrements each cycle. When it reaches 0, capture `MEM_RDATA` into `IR` (fetch) or `D_RDATA` (load), then go to DONE.
- **DONE:** pulse the matching ACK for one cycle and return to IDLE.
- **Back-to-back:** a request pending in the DONE cycle is not sampled. It is accepted in the following IDLE cycle.
- **Request dropped before grant:** never granted, with no side effects.
- **Request dropped after grant:** the access completes and the ACK still pulses.
- **Reset values:** state IDLE, `IR`=16'h0000 (LC3 BR never, acts as a NOP), `D_RDATA`=0, all ACKs, `MEM_EN`, `MEM_WE`, `BUSY`=0, `MEM_ADDR`/`MEM_WDATA`=0, fairness counter 0.
- **Reset mid-access:** the access is abandoned. No ACK is issued, and `MEM_EN`/`MEM_WE` are low from the next edge.
- **Addresses:** used unmodified. No wrap arithmetic is involved; 16'hFFFF is a legal address.

## Timing
- Requests are sampled in IDLE at cycle T. `MEM_EN` is high in T+1.
- Read: `MEM_RDATA` is captured at the end of T+1+`MEM_LAT`. The ACK and new `IR`/`D_RDATA` are visible in T+2+`MEM_LAT`. For `MEM_LAT`=1, ACK is at T+3.
- Store: write in T+1, `D_ACK` in T+2.
- `BUSY` is high from T+1 through the ACK cycle inclusive.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Minimum request-to-request spacing is 4 cycles for reads (`MEM_LAT`=1) and 3 cycles for stores.

## Structure
- **`lc3_pkg`** holds:
  - the FSM state enum;
  - `LC3_NOP` = 16'h0000;
  - `LC3_ADDR_W`/`LC3_DATA_W` = 16;
  - `FAIR_LIMIT` = 2.
- **Single module:** the FSM, latency counter, fairness counter and capture registers stay inline. No sub-module is warranted.

## Test plan
- **Reset:** `RST_N`=0 for 2 cycles, then release. `IR`=0000, all ACKs 0, `BUSY`=0, `MEM_EN`=0.
- **Fetch:** `IF_REQ`=1, `IF_ADDR`=3000h, memory returns 1234h (`MEM_LAT`=1).
  - `MEM_EN` with `MEM_ADDR`=3000h at T+1.
  - `IF_ACK` at T+3 with `IR`=1234h.
  - Repeat with `MEM_LAT`=3: ACK at T+5.
- **Store then load:** store `D_ADDR`=4000h, `D_WDATA`=BEEFh; then load 4000h.
  - `MEM_WE`=1 at T+1 and `D_ACK` at T+2.
  - The load returns `D_RDATA`=BEEFh.
- **Simultaneous requests and fairness:** `IF_REQ`, `D_REQ` held high, with a new data request issued after each `D_ACK`.
  - Grant order: data, data, fetch, data, data, fetch.
  - `IR` is unchanged during data accesses.
- **Reset mid-read:** assert `RST_N`=0 during WAIT.
  - No `IF_ACK`, `IR` returns to 0000, `BUSY`=0 after the edge.
  - A request after release completes normally.
- **Request glitch:** `D_REQ` pulses for 1 cycle while busy with a fetch. It is not granted, and `MEM_EN` count equals 1.
